// File: rtl/adc_channel_scanner.sv
// Conversion sequencer for an LTC2308 behind AdcReceiver. It paces requests, steps round-robin over
// the enabled channels, lines each result up with its channel despite the ADC config pipeline, and averages.
module adc_channel_scanner #(
   parameter int NUM_CH        = 8,
   parameter int SAMPLE_PERIOD = 2500,
   parameter int AVG_LOG2      = 2,
   parameter bit UNIPOLAR      = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_enable,
   input  logic [7:0]  i_ch_mask,
   output logic        o_request_conversion,
   output logic [5:0]  o_tx_bits,
   input  logic        i_rx_dv,
   input  logic [11:0] i_rx_data,
   input  logic        i_conv_in_process,
   output logic        o_sample_valid,
   output logic [2:0]  o_sample_ch,
   output logic [11:0] o_sample_data,
   output logic        o_overrun
);

   localparam int TIMER_W = $clog2(SAMPLE_PERIOD + 1);
   localparam int ACC_W   = 12 + AVG_LOG2;
   localparam int CNT_W   = AVG_LOG2 + 1;
   localparam logic [7:0] VALID_CH = 8'((9'd1 << NUM_CH) - 9'd1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

   typedef enum logic [1:0] {IDLE, WAIT_TICK, REQUEST, WAIT_DONE} state_t;

   state_t               state;
   state_t               state_next;
   logic [TIMER_W-1:0]   timer;
   logic                 tick;
   logic [7:0]           eff_mask;
   logic [2:0]           cur_ch;
   logic [2:0]           last_req_ch;
   logic [2:0]           prev_ch;
   logic [2:0]           next_ch;
   logic [2:0]           first_ch;
   logic [2:0]           req_ch;
   logic [2:0]           scan_idx;
   logic                 primed;
   logic                 rx_dv_q;
   logic                 dv_rise;
   logic [11:0]          sample;
   logic [ACC_W-1:0]     acc_sum;
   logic [ACC_W-1:0]     acc [0:NUM_CH-1];
   logic [CNT_W-1:0]     cnt [0:NUM_CH-1];

   function automatic logic [5:0] cfg_word(input logic [2:0] ch);
      return {1'b0, UNIPOLAR, ch[1], ch[2], ch[0], 1'b1};
   endfunction

   assign eff_mask = i_ch_mask & VALID_CH;
   assign dv_rise  = i_rx_dv & ~rx_dv_q;
   assign tick     = i_enable && (timer == TIMER_W'(SAMPLE_PERIOD - 1));
   assign acc_sum  = acc[prev_ch] + ACC_W'(sample);
   assign req_ch   = eff_mask[cur_ch] ? cur_ch : next_ch;

   always_comb begin
      for (int i = 0; i < 12; i++) begin
         sample[i] = i_rx_data[11 - i];
      end
   end

   // Sample-rate timer runs free while enabled so the request rate does not depend on FSM state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         timer <= '0;
      end else if (!i_enable || tick) begin
         timer <= '0;
      end else begin
         timer <= timer + 1'b1;
      end
   end

   always_comb begin
      next_ch  = cur_ch;
      scan_idx = cur_ch;
      for (int k = NUM_CH; k >= 1; k--) begin
         scan_idx = 3'((int'(cur_ch) + k) % NUM_CH);
         if (eff_mask[scan_idx]) begin
            next_ch = scan_idx;
         end
      end
   end

   always_comb begin
      first_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (eff_mask[3'(i)]) begin
            first_ch = 3'(i);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (i_enable) begin
               state_next = WAIT_TICK;
            end
         end
         WAIT_TICK: begin
            if (!i_enable) begin
               state_next = IDLE;
            end else if (tick && (eff_mask != 8'h00) && !i_conv_in_process) begin
               state_next = REQUEST;
            end
         end
         REQUEST: begin
            state_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (dv_rise) begin
               state_next = i_enable ? WAIT_TICK : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      o_request_conversion = (state == REQUEST);
   end

   // The result seen after request N carries the config of request N-1, hence prev_ch.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cur_ch         <= '0;
         last_req_ch    <= '0;
         prev_ch        <= '0;
         primed         <= 1'b0;
         rx_dv_q        <= 1'b0;
         o_tx_bits      <= '0;
         o_sample_valid <= 1'b0;
         o_sample_ch    <= '0;
         o_sample_data  <= '0;
         o_overrun      <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= '0;
            cnt[i] <= '0;
         end
      end else begin
         rx_dv_q        <= i_rx_dv;
         o_sample_valid <= 1'b0;
         if (tick && ((state == REQUEST) || (state == WAIT_DONE))) begin
            o_overrun <= 1'b1;
         end
         case (state)
            IDLE: begin
               primed <= 1'b0;
               for (int i = 0; i < NUM_CH; i++) begin
                  acc[i] <= '0;
                  cnt[i] <= '0;
               end
               if (i_enable) begin
                  cur_ch <= first_ch;
               end
            end
            WAIT_TICK: begin
               if (state_next == REQUEST) begin
                  cur_ch    <= req_ch;
                  o_tx_bits <= cfg_word(req_ch);
               end
            end
            REQUEST: begin
               prev_ch     <= last_req_ch;
               last_req_ch <= cur_ch;
            end
            WAIT_DONE: begin
               if (dv_rise) begin
                  cur_ch <= next_ch;
                  if (!primed) begin
                     primed <= 1'b1;
                  end else if (cnt[prev_ch] == LAST_CNT) begin
                     o_sample_valid <= 1'b1;
                     o_sample_ch    <= prev_ch;
                     o_sample_data  <= 12'(acc_sum >> AVG_LOG2);
                     acc[prev_ch]   <= '0;
                     cnt[prev_ch]   <= '0;
                  end else begin
                     acc[prev_ch] <= acc_sum;
                     cnt[prev_ch] <= cnt[prev_ch] + 1'b1;
                  end
               end
            end
            default: begin
               primed <= 1'b0;
            end
         endcase
      end
   end

endmodule
